// File: rtl/mult_dot_accumulator.sv
// Frame-based saturating accumulator for the 4x4 multiplier's product stream.
// Beats are summed until in_last, then the result is held on a valid/ready port.
module mult_dot_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,  // must be >= PROD_W
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_cnt
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [ACC_W-1:0]   out_sum_q;
    logic               out_ovf_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic               beat_acc;
    logic               res_acc;

    // Returns {overflow, sum}; once the sticky flag is set the sum pins at all-ones.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]  a,
                                               input logic [PROD_W-1:0] p,
                                               input logic              sticky);
        logic [ACC_W:0] wide;
        wide = {1'b0, a} + (ACC_W+1)'(p);
        if (wide[ACC_W] || sticky) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return wide;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end
        return c + CNT_W'(1);
    endfunction

    assign beat_acc = in_valid && in_ready_q;
    assign res_acc  = out_valid_q && out_ready;

    always_comb begin
        {ovf_d, acc_d} = sat_add(acc_q, in_prod, ovf_q);
        cnt_d          = sat_inc(cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_cnt_q   <= '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (beat_acc) begin
                        acc_q     <= acc_d;
                        ovf_q     <= ovf_d;
                        cnt_q     <= cnt_d;
                        out_sum_q <= acc_d;
                        out_ovf_q <= ovf_d;
                        out_cnt_q <= cnt_d;
                        if (in_last) begin
                            state_q     <= HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // Result registers stay put; only the running state clears.
                    if (res_acc) begin
                        state_q     <= ACCUM;
                        acc_q       <= '0;
                        ovf_q       <= 1'b0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ACCUM;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign out_cnt   = out_cnt_q;

endmodule
